// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: prescaled steps, clamped load, terminal-count pulse and hex digit drive.
// Define COUNTER_HEX_EN to build the 7-segment decoders; without it hex is tied high (blank).
module param_updown_counter #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter int              DIV        = 1,
  localparam int             NUM_DIGITS = (WIDTH + 3) / 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear_b,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_value,
  output logic [WIDTH-1:0]        Q,
  output logic                    tc,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

  logic [WIDTH-1:0] r_q;
  logic [15:0]      r_pre;
  logic             r_tc;

  logic             w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_step         = (r_pre == PRE_LAST);
  assign w_wrap         = up_down ? (r_q == MAX_COUNT) : (r_q == '0);
  assign w_load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  always_comb begin
    w_next = r_q;
    if (up_down)
      w_next = w_wrap ? '0 : r_q + WIDTH'(1);
    else
      w_next = w_wrap ? MAX_COUNT : r_q - WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q   <= '0;
      r_pre <= '0;
      r_tc  <= 1'b0;
    end else if (!clear_b) begin
      r_q   <= '0;
      r_pre <= '0;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_q   <= w_load_clamped;
      r_pre <= '0;
      r_tc  <= 1'b0;
    end else if (enable) begin
      if (w_step) begin
        r_q   <= w_next;
        r_pre <= '0;
        r_tc  <= w_wrap;
      end else begin
        r_pre <= r_pre + 16'd1;
        r_tc  <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign Q  = r_q;
  assign tc = r_tc;

`ifdef COUNTER_HEX_EN
  // Zero-extend Q so the top digit shows unused nibble bits as 0.
  logic [4*NUM_DIGITS-1:0] w_q_pad;
  assign w_q_pad = (4*NUM_DIGITS)'(r_q);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign hex[7*g +: 7] = seg_decode(w_q_pad[4*g +: 4]);
  end
`else
  assign hex = '1;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three parameterisations driven in parallel, a directed vector
// table, hand-written corner sequences and randomized traffic checked against an arithmetic model.
module tb_param_updown_counter;

  logic        clock = 1'b0;
  logic        reset_n, clear_b, enable, up_down, load;
  logic [7:0]  load_value;

  logic [7:0]  q8;  logic tc8; logic [13:0] hex8;
  logic [3:0]  q4;  logic tc4; logic [6:0]  hex4;
  logic [5:0]  q6;  logic tc6; logic [13:0] hex6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(8'd255), .DIV(1)) u8 (
    .clock(clock), .reset_n(reset_n), .clear_b(clear_b), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .Q(q8), .tc(tc8), .hex(hex8));

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .DIV(1)) u4 (
    .clock(clock), .reset_n(reset_n), .clear_b(clear_b), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value[3:0]), .Q(q4), .tc(tc4), .hex(hex4));

  param_updown_counter #(.WIDTH(6), .MAX_COUNT(6'd40), .DIV(3)) u6 (
    .clock(clock), .reset_n(reset_n), .clear_b(clear_b), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value[5:0]), .Q(q6), .tc(tc6), .hex(hex6));

  // Reference model: count value, enabled edges since last step, and last tc.
  typedef struct { int q; int pre; bit tc; } mstate_t;
  mstate_t m8, m4, m6;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic mstate_t mstep(mstate_t s, int maxc, int div, int lv,
                                    bit clr_b, bit ld, bit en, bit up);
    mstate_t n;
    n    = s;
    n.tc = 1'b0;
    if (!clr_b) begin
      n.q = 0; n.pre = 0;
    end else if (ld) begin
      n.q = (lv < maxc) ? lv : maxc; n.pre = 0;
    end else if (en) begin
      n.pre = (s.pre + 1) % div;
      if (n.pre == 0) begin
        if (up) begin
          n.q  = (s.q + 1) % (maxc + 1);
          n.tc = (n.q == 0);
        end else begin
          n.q  = (s.q + maxc) % (maxc + 1);
          n.tc = (n.q == maxc);
        end
      end
    end
    return n;
  endfunction

  function automatic logic [13:0] mhex(int q, int ndig);
    logic [13:0] r;
    r = '1;
`ifdef COUNTER_HEX_EN
    for (int i = 0; i < ndig; i++) r[7*i +: 7] = SEG[(q >> (4*i)) & 15];
`endif
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    logic [13:0] h;
    chk("q8", q8, m8.q);   chk("tc8", tc8, m8.tc);
    h = mhex(m8.q, 2);     chk("hex8", hex8, h);
    chk("q4", q4, m4.q);   chk("tc4", tc4, m4.tc);
    h = mhex(m4.q, 1);     chk("hex4", hex4, h[6:0]);
    chk("q6", q6, m6.q);   chk("tc6", tc6, m6.tc);
    h = mhex(m6.q, 2);     chk("hex6", hex6, h);
  endtask

  task automatic drive(bit clr_b, bit ld, logic [7:0] lv, bit en, bit up);
    clear_b = clr_b; load = ld; load_value = lv; enable = en; up_down = up;
  endtask

  task automatic cycle();
    @(posedge clock);
    m8 = mstep(m8, 255, 1, int'(load_value),      clear_b, load, enable, up_down);
    m4 = mstep(m4, 9,   1, int'(load_value[3:0]), clear_b, load, enable, up_down);
    m6 = mstep(m6, 40,  3, int'(load_value[5:0]), clear_b, load, enable, up_down);
    #1;
    compare_all();
  endtask

  typedef struct { bit clr_b; bit ld; logic [7:0] lv; bit en; bit up; logic [7:0] q; bit tc; } vec_t;
  vec_t vecs [15];

  localparam logic [13:0] HEX_00 =
`ifdef COUNTER_HEX_EN
    14'h2040;
`else
    14'h3FFF;
`endif
  localparam logic [13:0] HEX_3A =
`ifdef COUNTER_HEX_EN
    14'h1808;
`else
    14'h3FFF;
`endif

  initial begin
    m8 = '{0, 0, 1'b0}; m4 = '{0, 0, 1'b0}; m6 = '{0, 0, 1'b0};
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    #2;
    chk("reset q8", q8, 0); chk("reset tc8", tc8, 0); chk("reset hex8", hex8, HEX_00);
    #6 reset_n = 1'b1;

    // Directed vectors on the 8-bit instance (others tracked by the model).
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].clr_b, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up);
      cycle();
      chk($sformatf("vec%0d q8", i), q8, vecs[i].q);
      chk($sformatf("vec%0d tc8", i), tc8, vecs[i].tc);
    end

    // Modulus-9 down wrap and clamped load.
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cycle();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0); cycle();
    chk("mod9 down wrap q4", q4, 9); chk("mod9 down wrap tc4", tc4, 1);
    drive(1'b1, 1'b1, 8'h0F, 1'b0, 1'b1); cycle();
    chk("mod9 clamp q4", q4, 9); chk("mod9 clamp tc4", tc4, 0);

    // Prescaler DIV=3 from clear: steps at edges 3 and 6, pause keeps the partial count.
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cycle();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      cycle();
      chk($sformatf("div3 edge%0d q6", e), q6, (e >= 6) ? 2 : (e >= 3) ? 1 : 0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int e = 0; e < 5; e++) cycle();
    chk("div3 paused q6", q6, 2);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(); chk("div3 resume edge1 q6", q6, 2);
    cycle(); chk("div3 resume edge2 q6", q6, 3);
    cycle();

    // Async reset mid-count discards the prescaler; restart needs a full period.
    reset_n = 1'b0;
    #2;
    chk("async reset q6", q6, 0); chk("async reset q8", q8, 0);
    chk("async reset tc8", tc8, 0); chk("async reset hex8", hex8, HEX_00);
    m8 = '{0, 0, 1'b0}; m4 = '{0, 0, 1'b0}; m6 = '{0, 0, 1'b0};
    #1 reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      chk($sformatf("post-reset edge%0d q6", e), q6, (e == 3) ? 1 : 0);
    end

    // Count to 0x3A and check the digit drive.
    drive(1'b1, 1'b1, 8'h39, 1'b0, 1'b1); cycle();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1); cycle();
    chk("count 3A q8", q8, 8'h3A); chk("count 3A hex8", hex8, HEX_3A);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 20) != 0, ($urandom % 15) == 0, 8'($urandom),
            ($urandom % 4) != 0, 1'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
